// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: clk / (div_int + div_frac/2^FRAC_W) gives the
// oversample strobe, and every OVERSAMPLE of those gives a baud strobe and a clk_out toggle.
module baud_gen_frac #(
  parameter int DIV_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 325,
  parameter int DEFAULT_DIV_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              clk_out,
  output logic              div_pending
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = '1;
  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);
  localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_int;
  logic [DIV_W-1:0]  shadow_int;
  logic [DIV_W-1:0]  last;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] div_frac;
  logic [FRAC_W-1:0] shadow_frac;
  logic [FRAC_W-1:0] frac_sum;
  logic [OS_W-1:0]   os_cnt;
  logic              extra;
  logic              carry;
  logic              wrap;

  // The extra cycle is dropped at the largest divisor so period-1 still fits in cnt.
  always_comb begin
    last = div_int - DIV_W'(1);
    if (extra && (div_int != DIV_MAX))
      last = div_int;
  end

  // ">=" rather than "==" so a divisor shrunk mid-interval (en low) cannot overrun.
  assign wrap = en && !restart && (cnt >= last);
  assign {carry, frac_sum} = {1'b0, frac_acc} + {1'b0, div_frac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      frac_acc    <= '0;
      extra       <= 1'b0;
      os_cnt      <= '0;
      div_int     <= DEF_INT;
      div_frac    <= DEF_FRAC;
      shadow_int  <= DEF_INT;
      shadow_frac <= DEF_FRAC;
      div_pending <= 1'b0;
      os_tick     <= 1'b0;
      baud_tick   <= 1'b0;
      clk_out     <= 1'b0;
    end else begin
      os_tick   <= wrap;
      baud_tick <= wrap && (os_cnt == OS_LAST);
      if (restart) begin
        cnt      <= '0;
        frac_acc <= '0;
        extra    <= 1'b0;
        os_cnt   <= OS_HALF;
      end else if (en) begin
        if (wrap) begin
          cnt      <= '0;
          frac_acc <= frac_sum;
          extra    <= carry;
          os_cnt   <= os_cnt + OS_W'(1);
          if (os_cnt == OS_LAST)
            clk_out <= ~clk_out;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
      // A write in the same cycle as an activation stays pending for the next boundary.
      if (div_pending && (wrap || !en || restart)) begin
        div_int     <= shadow_int;
        div_frac    <= shadow_frac;
        div_pending <= 1'b0;
      end
      if (div_wr) begin
        shadow_int  <= (div_int_in < DIV_MIN) ? DIV_MIN : div_int_in;
        shadow_frac <= div_frac_in;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac with an interval-level reference model checked every cycle.
module tb_baud_gen_frac;

  localparam int DW    = 16;
  localparam int FW    = 4;
  localparam int OS    = 4;
  localparam int DINT  = 4;
  localparam int DFRAC = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          restart;
  logic          div_wr;
  logic [DW-1:0] div_int_in;
  logic [FW-1:0] div_frac_in;
  logic          os_tick;
  logic          baud_tick;
  logic          clk_out;
  logic          div_pending;

  int errors = 0;
  int checks = 0;
  int cyc;
  int base;
  int t0;
  int t1;
  int n;
  int os_at[$];
  int baud_at[$];

  int m_int, m_frac, m_sh_int, m_sh_frac;
  int m_done, m_extra, m_fsum, m_ostot;
  bit m_pend, m_clk, m_os, m_baud;

  always #5 clk = ~clk;

  baud_gen_frac #(
    .DIV_W(DW),
    .FRAC_W(FW),
    .OVERSAMPLE(OS),
    .DEFAULT_DIV_INT(DINT),
    .DEFAULT_DIV_FRAC(DFRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .restart(restart),
    .div_wr(div_wr),
    .div_int_in(div_int_in),
    .div_frac_in(div_frac_in),
    .os_tick(os_tick),
    .baud_tick(baud_tick),
    .clk_out(clk_out),
    .div_pending(div_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_int = DINT; m_frac = DFRAC; m_sh_int = DINT; m_sh_frac = DFRAC;
    m_pend = 1'b0; m_done = 0; m_extra = 0; m_fsum = 0; m_ostot = 0;
    m_clk = 1'b0; m_os = 1'b0; m_baud = 1'b0;
  endtask

  // Interval view: an interval lasts div_int (+1 when the running fraction total
  // crosses a whole clock); baud falls on every OS-th tick counted from the phase origin.
  task automatic model_edge();
    bit bnd;
    int len;
    bnd = 1'b0; m_os = 1'b0; m_baud = 1'b0;
    if (restart) begin
      m_done = 0; m_fsum = 0; m_extra = 0; m_ostot = OS / 2;
    end else if (en) begin
      len = m_int + ((m_int == (1 << DW) - 1) ? 0 : m_extra);
      if (m_done + 1 >= len) begin
        bnd = 1'b1; m_os = 1'b1; m_done = 0;
        m_extra = (((m_fsum + m_frac) / (1 << FW)) != (m_fsum / (1 << FW))) ? 1 : 0;
        m_fsum += m_frac;
        m_ostot++;
        if (m_ostot % OS == 0) begin
          m_baud = 1'b1;
          m_clk = !m_clk;
        end
      end else begin
        m_done++;
      end
    end
    if (m_pend && (bnd || !en || restart)) begin
      m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 1'b0;
    end
    if (div_wr) begin
      m_sh_int = (int'(div_int_in) < 2) ? 2 : int'(div_int_in);
      m_sh_frac = int'(div_frac_in);
      m_pend = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("os_tick", os_tick, m_os);
    check("baud_tick", baud_tick, m_baud);
    check("clk_out", clk_out, m_clk);
    check("div_pending", div_pending, m_pend);
    if (os_tick === 1'b1) os_at.push_back(cyc);
    if (baud_tick === 1'b1) baud_at.push_back(cyc);
  endtask

  task automatic wait_os(output int t);
    bit found;
    found = 1'b0;
    t = cyc;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (os_tick === 1'b1) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("wait_os", found, 1);
  endtask

  task automatic clear_log();
    os_at.delete();
    baud_at.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; restart = 1'b0; div_wr = 1'b0;
    div_int_in = '0; div_frac_in = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    check("rst os_tick", os_tick, 0);
    check("rst baud_tick", baud_tick, 0);
    check("rst clk_out", clk_out, 0);
    check("rst div_pending", div_pending, 0);

    // Default divisor 4, no fraction
    rst = 1'b0; en = 1'b1;
    base = cyc; clear_log();
    repeat (50) step();
    check("t1 first os", os_at[0] - base, 4);
    check("t1 os gap", os_at[1] - os_at[0], 4);
    check("t1 first baud", baud_at[0] - base, 16);
    check("t1 baud gap", baud_at[1] - baud_at[0], 16);
    check("t1 clk_out period", baud_at[2] - baud_at[0], 32);

    // Fractional 4 + 8/16
    div_int_in = 16'd4; div_frac_in = 4'd8; div_wr = 1'b1; step(); div_wr = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    base = cyc; clear_log();
    repeat (160) step();
    check("t2 iv1", os_at[0] - base, 4);
    check("t2 iv2", os_at[1] - os_at[0], 4);
    check("t2 iv3", os_at[2] - os_at[1], 5);
    check("t2 iv4", os_at[3] - os_at[2], 4);
    check("t2 iv5", os_at[4] - os_at[3], 5);
    check("t2 32 intervals", os_at[32] - os_at[0], 144);

    // Restart exactly when a tick is due
    div_int_in = 16'd4; div_frac_in = 4'd0; div_wr = 1'b1; step(); div_wr = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    wait_os(t0);
    repeat (3) step();
    restart = 1'b1; step(); restart = 1'b0;
    check("t3 tick suppressed", os_tick, 0);
    base = cyc; clear_log();
    repeat (30) step();
    check("t3 first os", os_at[0] - base, 4);
    check("t3 first baud", baud_at[0] - base, 8);
    check("t3 second baud", baud_at[1] - base, 24);

    // Divisor write mid-interval
    wait_os(t0);
    step();
    div_int_in = 16'd6; div_wr = 1'b1; step(); div_wr = 1'b0;
    check("t4 pending", div_pending, 1);
    clear_log();
    repeat (24) step();
    check("t4 current iv", os_at[0] - t0, 4);
    check("t4 new iv a", os_at[1] - os_at[0], 6);
    check("t4 new iv b", os_at[2] - os_at[1], 6);
    check("t4 pending cleared", div_pending, 0);
    div_int_in = 16'd1; div_wr = 1'b1; step(); div_wr = 1'b0;
    clear_log();
    repeat (30) step();
    n = os_at.size();
    check("t4 clamp ticks", (n >= 3) ? 1 : 0, 1);
    if (n >= 2) check("t4 clamp period", os_at[n-1] - os_at[n-2], 2);

    // Enable freeze mid-count
    div_int_in = 16'd4; div_wr = 1'b1; step(); div_wr = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    wait_os(t0);
    repeat (2) step();
    en = 1'b0; clear_log();
    repeat (10) step();
    check("t5 frozen ticks", os_at.size(), 0);
    en = 1'b1;
    wait_os(t1);
    check("t5 resume", t1 - t0, 14);
    en = 1'b0; div_int_in = 16'd5; div_wr = 1'b1; step(); div_wr = 1'b0;
    check("t5 pending while off", div_pending, 1);
    step();
    check("t5 immediate apply", div_pending, 0);
    en = 1'b1;
    wait_os(t0);
    wait_os(t1);
    check("t5 new period", t1 - t0, 5);

    // Asynchronous reset with a pending divisor
    wait_os(t0);
    div_int_in = 16'd9; div_wr = 1'b1; step(); div_wr = 1'b0;
    check("t6 pending", div_pending, 1);
    step();
    #2 rst = 1'b1;
    #1;
    check("t6 async os_tick", os_tick, 0);
    check("t6 async baud_tick", baud_tick, 0);
    check("t6 async clk_out", clk_out, 0);
    check("t6 async pending", div_pending, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    base = cyc; clear_log();
    repeat (12) step();
    check("t6 default first os", os_at[0] - base, 4);
    check("t6 default gap", os_at[1] - os_at[0], 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
